// File: rtl/instruction_fetch.sv
// Program-sequencing front end: program counter, instruction register and a
// circular return stack feeding the instruction decoder.
module instruction_fetch #(
    parameter int          STACK_DEPTH  = 8,
    parameter logic [12:0] RESET_VECTOR = 13'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_rd_en,
    input  logic        instr_flush,
    input  logic        pc_incr_en,
    input  logic        pc_j_en,
    input  logic        pc_call_en,
    input  logic        pc_ret_en,
    input  logic [4:0]  pclath,
    output logic [12:0] prog_addr,
    input  logic [13:0] prog_data,
    output logic [13:0] instr_current,
    output logic [12:0] pc,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int               SP_W     = $clog2(STACK_DEPTH);
    localparam int               CNT_W    = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

    logic [12:0]      stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]  sp;
    logic [SP_W-1:0]  sp_dec;
    logic [CNT_W-1:0] count;
    logic [12:0]      jump_target;
    logic             do_push;
    logic             unused_pclath;

    // Only the page bits of PCLATH take part in jump targets.
    assign unused_pclath = ^pclath[2:0];

    // Target uses the IR contents present in the strobe cycle.
    assign jump_target = {pclath[4:3], instr_current[10:0]};
    assign sp_dec      = sp - 1'b1;
    assign prog_addr   = pc;

    // A return outranks a call, and reset suppresses any stack write.
    assign do_push = !rst && !pc_ret_en && pc_call_en;

    // PC sequencing, stack pointer, occupancy count and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_VECTOR;
            sp              <= '0;
            count           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (pc_ret_en) begin
            pc <= stack_mem[sp_dec];
            sp <= sp_dec;
            if (count == '0) begin
                stack_underflow <= 1'b1;
            end else begin
                count <= count - 1'b1;
            end
        end else if (pc_call_en) begin
            pc <= jump_target;
            sp <= sp + 1'b1;
            if (count == CNT_FULL) begin
                stack_overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pc_j_en) begin
            pc <= jump_target;
        end else if (pc_incr_en) begin
            pc <= pc + 13'd1;
        end
    end

    // Return-stack storage; pushes the pre-edge PC, which is already the return address.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[sp] <= pc;
        end
    end

    // Instruction register: flush inserts a NOP, otherwise load the word at the old PC.
    always_ff @(posedge clk) begin
        if (rst || instr_flush) begin
            instr_current <= 14'h0000;
        end else if (instr_rd_en) begin
            instr_current <= prog_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        instr_rd_en;
    logic        instr_flush;
    logic        pc_incr_en;
    logic        pc_j_en;
    logic        pc_call_en;
    logic        pc_ret_en;
    logic [4:0]  pclath;
    logic [12:0] prog_addr;
    logic [13:0] prog_data;
    logic [13:0] instr_current;
    logic [12:0] pc;
    logic        stack_overflow;
    logic        stack_underflow;

    logic [13:0] rom [8192];
    int errors;
    int checks;

    instruction_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .instr_rd_en     (instr_rd_en),
        .instr_flush     (instr_flush),
        .pc_incr_en      (pc_incr_en),
        .pc_j_en         (pc_j_en),
        .pc_call_en      (pc_call_en),
        .pc_ret_en       (pc_ret_en),
        .pclath          (pclath),
        .prog_addr       (prog_addr),
        .prog_data       (prog_data),
        .instr_current   (instr_current),
        .pc              (pc),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    // Asynchronous program ROM model.
    assign prog_data = rom[prog_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rst         = 1'b0;
        instr_rd_en = 1'b0;
        instr_flush = 1'b0;
        pc_incr_en  = 1'b0;
        pc_j_en     = 1'b0;
        pc_call_en  = 1'b0;
        pc_ret_en   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; instr_rd_en = 1'b1; instr_flush = 1'b1; pc_incr_en = 1'b1;
        pc_j_en = 1'b1; pc_call_en = 1'b1; pc_ret_en = 1'b1; pclath = 5'b11111;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        idle();
        pclath = 5'b00000;
        checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 13'h0000); end
        checks++; if (prog_addr !== 13'h0000) begin errors++; $display("FAIL reset_prog_addr: got %h expected %h", prog_addr, 13'h0000); end
        checks++; if (instr_current !== 14'h0000) begin errors++; $display("FAIL reset_ir: got %h expected %h", instr_current, 14'h0000); end
        checks++; if ({stack_overflow, stack_underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected %b", {stack_overflow, stack_underflow}, 2'b00); end
        checks++; if (dut.count !== 0) begin errors++; $display("FAIL reset_count: got %0d expected 0", dut.count); end
        rom[0] = 14'h3055;
        instr_rd_en = 1'b1; pc_incr_en = 1'b1;
        tick();
        checks++; if (instr_current !== 14'h3055) begin errors++; $display("FAIL first_fetch_ir: got %h expected %h", instr_current, 14'h3055); end
        checks++; if (pc !== 13'h0001) begin errors++; $display("FAIL first_fetch_pc: got %h expected %h", pc, 13'h0001); end
    endtask

    task automatic test_skip();
        for (int i = 0; i < 4; i++) begin
            pc_incr_en = 1'b1;
            tick();
        end
        checks++; if (pc !== 13'h0005) begin errors++; $display("FAIL skip_setup_pc: got %h expected %h", pc, 13'h0005); end
        rom[5] = 14'h1234;
        rom[6] = 14'h0ABC;
        instr_flush = 1'b1; pc_incr_en = 1'b1;
        tick();
        checks++; if (instr_current !== 14'h0000) begin errors++; $display("FAIL skip_ir: got %h expected %h", instr_current, 14'h0000); end
        checks++; if (pc !== 13'h0006) begin errors++; $display("FAIL skip_pc: got %h expected %h", pc, 13'h0006); end
        instr_rd_en = 1'b1; pc_incr_en = 1'b1;
        tick();
        checks++; if (instr_current !== 14'h0ABC) begin errors++; $display("FAIL after_skip_ir: got %h expected %h", instr_current, 14'h0ABC); end
        checks++; if (pc !== 13'h0007) begin errors++; $display("FAIL after_skip_pc: got %h expected %h", pc, 13'h0007); end
    endtask

    task automatic test_jump();
        rom[7] = 14'h2ABC;
        instr_rd_en = 1'b1;
        tick();
        checks++; if (instr_current !== 14'h2ABC) begin errors++; $display("FAIL jump_setup_ir: got %h expected %h", instr_current, 14'h2ABC); end
        pclath = 5'b11000;
        pc_j_en = 1'b1; pc_incr_en = 1'b1; instr_flush = 1'b1;
        tick();
        pclath = 5'b00000;
        checks++; if (pc !== 13'h1ABC) begin errors++; $display("FAIL jump_pc: got %h expected %h", pc, 13'h1ABC); end
        checks++; if (instr_current !== 14'h0000) begin errors++; $display("FAIL jump_ir: got %h expected %h", instr_current, 14'h0000); end
    endtask

    task automatic test_call_ret();
        rom[13'h1ABC] = 14'h2010;
        instr_rd_en = 1'b1;
        tick();
        pc_j_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h0010) begin errors++; $display("FAIL call_setup_pc: got %h expected %h", pc, 13'h0010); end
        rom[13'h0010] = 14'h2100;
        instr_rd_en = 1'b1;
        tick();
        pc_call_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h0100) begin errors++; $display("FAIL call_pc: got %h expected %h", pc, 13'h0100); end
        checks++; if (dut.count !== 1) begin errors++; $display("FAIL call_count: got %0d expected 1", dut.count); end
        pc_ret_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h0010) begin errors++; $display("FAIL ret_pc: got %h expected %h", pc, 13'h0010); end
        checks++; if (dut.count !== 0) begin errors++; $display("FAIL ret_count: got %0d expected 0", dut.count); end
        checks++; if ({stack_overflow, stack_underflow} !== 2'b00) begin errors++; $display("FAIL call_ret_flags: got %b expected %b", {stack_overflow, stack_underflow}, 2'b00); end
    endtask

    task automatic test_stack_wrap();
        logic [12:0] exp_pc;
        do_reset();
        pclath = 5'b00000;
        pc_incr_en = 1'b1;
        tick();
        for (int k = 1; k <= 9; k++) begin
            rom[k] = 14'h2000 | 14'(k + 1);
            instr_rd_en = 1'b1;
            tick();
            pc_call_en = 1'b1;
            tick();
            exp_pc = 13'(k + 1);
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL nest_call_pc[%0d]: got %h expected %h", k, pc, exp_pc); end
            if (k == 8) begin
                checks++; if (stack_overflow !== 1'b0) begin errors++; $display("FAIL overflow_early: got %b expected 0", stack_overflow); end
            end
        end
        checks++; if (stack_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", stack_overflow); end
        for (int i = 0; i < 8; i++) begin
            pc_ret_en = 1'b1;
            tick();
            exp_pc = 13'(9 - i);
            checks++; if (pc !== exp_pc) begin errors++; $display("FAIL nest_ret_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
        end
        checks++; if (stack_underflow !== 1'b0) begin errors++; $display("FAIL underflow_early: got %b expected 0", stack_underflow); end
        pc_ret_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h0009) begin errors++; $display("FAIL wrapped_ret_pc: got %h expected %h", pc, 13'h0009); end
        checks++; if (stack_underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", stack_underflow); end
        checks++; if (stack_overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %b expected 1", stack_overflow); end
    endtask

    task automatic test_wrap_priority();
        do_reset();
        // PC wrap at the top of program memory
        rom[0] = 14'h07FF;
        pclath = 5'b11000;
        instr_rd_en = 1'b1;
        tick();
        pc_j_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h1FFF) begin errors++; $display("FAIL wrap_setup_pc: got %h expected %h", pc, 13'h1FFF); end
        pc_incr_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL pc_wrap: got %h expected %h", pc, 13'h0000); end

        // Return wins over call/jump/increment, with no push
        do_reset();
        pclath = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            pc_incr_en = 1'b1;
            tick();
        end
        rom[3] = 14'h0020;
        instr_rd_en = 1'b1;
        tick();
        pc_call_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h0020) begin errors++; $display("FAIL prio_call_pc: got %h expected %h", pc, 13'h0020); end
        rom[13'h0020] = 14'h0300;
        instr_rd_en = 1'b1;
        tick();
        pc_ret_en = 1'b1; pc_call_en = 1'b1; pc_j_en = 1'b1; pc_incr_en = 1'b1;
        tick();
        checks++; if (pc !== 13'h0003) begin errors++; $display("FAIL prio_ret_pc: got %h expected %h", pc, 13'h0003); end
        checks++; if (dut.count !== 0) begin errors++; $display("FAIL prio_count: got %0d expected 0", dut.count); end
        checks++; if (dut.sp !== 0) begin errors++; $display("FAIL prio_sp: got %0d expected 0", dut.sp); end
        checks++; if ({stack_overflow, stack_underflow} !== 2'b00) begin errors++; $display("FAIL prio_flags: got %b expected %b", {stack_overflow, stack_underflow}, 2'b00); end

        // Reset in the middle of a call sequence, carrying a call strobe
        instr_rd_en = 1'b1;
        tick();
        pc_call_en = 1'b1;
        tick();
        pc_ret_en = 1'b1;
        tick();
        pc_ret_en = 1'b1;
        tick();
        checks++; if (stack_underflow !== 1'b1) begin errors++; $display("FAIL pre_rst_underflow: got %b expected 1", stack_underflow); end
        instr_rd_en = 1'b1;
        tick();
        pc_call_en = 1'b1;
        tick();
        rst = 1'b1; pc_call_en = 1'b1;
        tick();
        checks++; if (dut.sp !== 0) begin errors++; $display("FAIL rst_sp: got %0d expected 0", dut.sp); end
        checks++; if (dut.count !== 0) begin errors++; $display("FAIL rst_count: got %0d expected 0", dut.count); end
        checks++; if ({stack_overflow, stack_underflow} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b expected %b", {stack_overflow, stack_underflow}, 2'b00); end
        checks++; if (pc !== 13'h0000) begin errors++; $display("FAIL rst_pc: got %h expected %h", pc, 13'h0000); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 8192; i++) rom[i] = 14'(i * 3 + 7);
        pclath = 5'b00000;
        idle();
        test_reset();
        test_skip();
        test_jump();
        test_call_ret();
        test_stack_wrap();
        test_wrap_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
